// File: rtl/afifo_rd_port_if.sv
// rtl/afifo_rd_port_if.sv - output word stream of the async FIFO read-side consumer
interface afifo_rd_port_if #(
    parameter int DW = 8
);
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/afifo_rd_port.sv
// rtl/afifo_rd_port.sv - drains drain_len words from the async FIFO read port onto a valid/ready stream
// Optional stall statistic: define AFIFO_RD_STATS_EN.
module afifo_rd_port #(
    parameter int DW   = 8,
    parameter int CNTW = 16
) (
    input  logic            rdclk,
    input  logic            arst,
    input  logic            start,
    input  logic [CNTW-1:0] drain_len,
    input  logic            fifo_empty,
    output logic            fifo_rd_en,
    input  logic [DW-1:0]   fifo_rdata,
    afifo_rd_port_if.master m,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] word_cnt,
    output logic [CNTW-1:0] stall_cnt
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [CNTW-1:0] remaining;
    logic [1:0]      occ;
    logic            inflight;
    logic [DW-1:0]   head;
    logic [DW-1:0]   tail;
    logic [1:0]      level;
    logic            hs;
    logic            last_hs;

    // The word arriving from the FIFO counts as held: it is offered straight
    // through when the buffer is empty, which gives the 2-cycle start latency.
    assign level      = occ + {1'b0, inflight};
    assign fifo_rd_en = (state == RUN) && !fifo_empty && (remaining != '0) && (level < 2'd2);
    assign m.m_valid  = (level != 2'd0);
    assign m.m_data   = ((occ == 2'd0) && inflight) ? fifo_rdata : head;
    assign hs         = m.m_valid && m.m_ready;
    assign last_hs    = (state == RUN) && hs && (remaining == '0) && (level == 2'd1);

    always_ff @(posedge rdclk or posedge arst) begin
        if (arst) begin
            state     <= IDLE;
            remaining <= '0;
            occ       <= 2'd0;
            inflight  <= 1'b0;
            head      <= '0;
            tail      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            word_cnt  <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= fifo_rd_en;
            if (fifo_rd_en)
                remaining <= remaining - CNTW'(1);
            if (hs)
                word_cnt <= word_cnt + CNTW'(1);

            case (occ)
                2'd0: begin
                    if (inflight && !hs) begin
                        head <= fifo_rdata;
                        occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (inflight && hs) begin
                        head <= fifo_rdata;
                    end else if (inflight) begin
                        tail <= fifo_rdata;
                        occ  <= 2'd2;
                    end else if (hs) begin
                        occ <= 2'd0;
                    end
                end
                default: begin
                    // The credit rule keeps inflight low whenever both entries are full.
                    if (hs) begin
                        head <= tail;
                        occ  <= 2'd1;
                    end
                end
            endcase

            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= drain_len;
                        word_cnt  <= '0;
                        if (drain_len != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (last_hs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AFIFO_RD_STATS_EN
    always_ff @(posedge rdclk or posedge arst) begin
        if (arst) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cnt <= '0;
        end else if ((state == RUN) && ((m.m_valid && !m.m_ready) || (fifo_empty && (remaining != '0)))
                     && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNTW'(1);
        end
    end
`else
    assign stall_cnt = '0;
`endif
endmodule
